// File: rtl/meikyuu_pkg.sv
// Shared maze constants: VGA timing, sprite limits, direction and FSM encodings.
package meikyuu_pkg;

  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BACK   = 48;
  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FRONT  = 16;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BACK   = 33;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FRONT  = 10;
  localparam int unsigned SPRITE   = 16;

  localparam int unsigned X_MIN = H_SYNC + H_BACK - SPRITE;
  localparam int unsigned X_MAX = H_SYNC + H_BACK + H_ACTIVE - SPRITE;
  localparam int unsigned Y_MIN = V_SYNC + V_BACK;
  localparam int unsigned Y_MAX = V_SYNC + V_BACK + V_ACTIVE - SPRITE;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_TICK,
    ST_CHECK,
    ST_WRAP,
    ST_COMMIT
  } state_e;

  // Active-low buttons; left beats down beats up beats right.
  function automatic dir_e resolve_dir(input logic up_n, input logic down_n,
                                       input logic left_n, input logic right_n);
    if (!left_n)      return DIR_LEFT;
    else if (!down_n) return DIR_DOWN;
    else if (!up_n)   return DIR_UP;
    else              return DIR_RIGHT;
  endfunction

endpackage

// File: rtl/player_move_ctrl_if.sv
// Collision-check handshake between the move controller and the collision unit.
interface player_move_ctrl_if;
  logic       chk_req;
  logic [9:0] chk_x;
  logic [9:0] chk_y;
  logic       chk_ack;
  logic       chk_blocked;

  modport master (output chk_req, output chk_x, output chk_y,
                  input  chk_ack, input  chk_blocked);
  modport slave  (input  chk_req, input  chk_x, input  chk_y,
                  output chk_ack, output chk_blocked);
endinterface

// File: rtl/move_tick_gen.sv
// Step pacing counter: counts while enabled, ticks on its last count and restarts.
module move_tick_gen #(
  parameter int unsigned TICK_MAX = 150000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);
  localparam int unsigned CW = $clog2(TICK_MAX + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == CW'(TICK_MAX - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = tick_o ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
endmodule

// File: rtl/player_move_ctrl.sv
// Player step sequencer: paces button-driven steps, asks the collision unit
// about each candidate and commits it, or wraps into the neighbouring room.
module player_move_ctrl
  import meikyuu_pkg::*;
#(
  parameter int unsigned TICK_MAX    = 150000,
  parameter int unsigned X_MIN       = meikyuu_pkg::X_MIN,
  parameter int unsigned X_MAX       = meikyuu_pkg::X_MAX,
  parameter int unsigned Y_MIN       = meikyuu_pkg::Y_MIN,
  parameter int unsigned Y_MAX       = meikyuu_pkg::Y_MAX,
  parameter int unsigned X_START     = 439,
  parameter int unsigned Y_START     = 266,
  parameter int unsigned MAP_START   = 1,
  parameter int unsigned CHK_TIMEOUT = 15
) (
  input  logic                      CLOCK_25,
  input  logic                      reset,
  input  logic                      btn_up,
  input  logic                      btn_down,
  input  logic                      btn_left,
  input  logic                      btn_right,
  player_move_ctrl_if.master        chk,
  output logic [9:0]                x_pos,
  output logic [9:0]                y_pos,
  output logic [2:0]                mapa_x,
  output logic [2:0]                mapa_y,
  output logic [1:0]                dir,
  output logic                      step_done
);
  localparam int unsigned WW = $clog2(CHK_TIMEOUT + 1);

  state_e          state_q, state_d, rest_state;
  dir_e            dir_q, dir_d, res_dir;
  logic [9:0]      x_q, x_d, y_q, y_d, cx_q, cx_d, cy_q, cy_d, nx, ny;
  logic [2:0]      mx_q, mx_d, my_q, my_d, nmx, nmy;
  logic [WW-1:0]   wait_q, wait_d;
  logic            any_btn, wrap, tick, tick_clr, tick_en;

  assign any_btn    = ~(btn_up & btn_down & btn_left & btn_right);
  assign res_dir    = resolve_dir(btn_up, btn_down, btn_left, btn_right);
  assign rest_state = any_btn ? ST_WAIT_TICK : ST_IDLE;

  move_tick_gen #(.TICK_MAX(TICK_MAX)) u_tick (
    .clk_i  (CLOCK_25),
    .rst_ni (reset),
    .clr_i  (tick_clr),
    .en_i   (tick_en),
    .tick_o (tick)
  );

  // A step off the visible area turns into a jump to the opposite edge of the next room.
  always_comb begin
    nx   = x_q;
    ny   = y_q;
    nmx  = mx_q;
    nmy  = my_q;
    wrap = 1'b0;
    unique case (res_dir)
      DIR_UP:    if (y_q == 10'(Y_MIN)) begin wrap = 1'b1; ny = 10'(Y_MAX); nmy = my_q - 3'd1; end
                 else ny = y_q - 10'd1;
      DIR_DOWN:  if (y_q == 10'(Y_MAX)) begin wrap = 1'b1; ny = 10'(Y_MIN); nmy = my_q + 3'd1; end
                 else ny = y_q + 10'd1;
      DIR_LEFT:  if (x_q == 10'(X_MIN)) begin wrap = 1'b1; nx = 10'(X_MAX); nmx = mx_q - 3'd1; end
                 else nx = x_q - 10'd1;
      DIR_RIGHT: if (x_q == 10'(X_MAX)) begin wrap = 1'b1; nx = 10'(X_MIN); nmx = mx_q + 3'd1; end
                 else nx = x_q + 10'd1;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    x_d      = x_q;
    y_d      = y_q;
    mx_d     = mx_q;
    my_d     = my_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    wait_d   = wait_q;
    tick_clr = 1'b0;
    tick_en  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        tick_clr = 1'b1;
        if (any_btn) begin
          dir_d   = res_dir;
          state_d = ST_WAIT_TICK;
        end
      end
      ST_WAIT_TICK: begin
        if (!any_btn) begin
          tick_clr = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          tick_en = 1'b1;
          if (tick) begin
            dir_d = res_dir;
            if (wrap) begin
              // Position and room land together with the step_done pulse.
              x_d     = nx;
              y_d     = ny;
              mx_d    = nmx;
              my_d    = nmy;
              state_d = ST_WRAP;
            end else begin
              cx_d    = nx;
              cy_d    = ny;
              wait_d  = '0;
              state_d = ST_CHECK;
            end
          end
        end
      end
      ST_CHECK: begin
        if (chk.chk_ack) begin
          if (!chk.chk_blocked) begin
            x_d     = cx_q;
            y_d     = cy_q;
            state_d = ST_COMMIT;
          end else begin
            state_d = rest_state;
          end
        end else if (wait_q == WW'(CHK_TIMEOUT - 1)) begin
          state_d = rest_state;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      ST_WRAP, ST_COMMIT: state_d = rest_state;
      default:            state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_25 or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      dir_q   <= DIR_UP;
      x_q     <= 10'(X_START);
      y_q     <= 10'(Y_START);
      mx_q    <= 3'(MAP_START);
      my_q    <= 3'(MAP_START);
      cx_q    <= '0;
      cy_q    <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      x_q     <= x_d;
      y_q     <= y_d;
      mx_q    <= mx_d;
      my_q    <= my_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      wait_q  <= wait_d;
    end
  end

  assign chk.chk_req = (state_q == ST_CHECK);
  assign chk.chk_x   = cx_q;
  assign chk.chk_y   = cy_q;
  assign x_pos       = x_q;
  assign y_pos       = y_q;
  assign mapa_x      = mx_q;
  assign mapa_y      = my_q;
  assign dir         = dir_q;
  assign step_done   = (state_q == ST_WRAP) || (state_q == ST_COMMIT);
endmodule

// File: tb/tb_player_move_ctrl.sv
// Bench for player_move_ctrl: directed scenarios plus randomized buttons and checker replies.
module tb_player_move_ctrl;
  localparam int TICK_MAX    = 4;
  localparam int CHK_TIMEOUT = 3;
  localparam int X_MIN = 128, X_MAX = 768, Y_MIN = 35, Y_MAX = 499;
  localparam int X_START = 439, Y_START = 266, MAP_START = 1;

  logic       CLOCK_25 = 1'b0;
  logic       reset = 1'b0;
  logic       btn_up = 1'b1, btn_down = 1'b1, btn_left = 1'b1, btn_right = 1'b1;
  logic [9:0] x_pos, y_pos;
  logic [2:0] mapa_x, mapa_y;
  logic [1:0] dir;
  logic       step_done;

  player_move_ctrl_if chk_bus ();

  player_move_ctrl #(.TICK_MAX(TICK_MAX), .CHK_TIMEOUT(CHK_TIMEOUT)) dut (
    .CLOCK_25  (CLOCK_25),
    .reset     (reset),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .chk       (chk_bus),
    .x_pos     (x_pos),
    .y_pos     (y_pos),
    .mapa_x    (mapa_x),
    .mapa_y    (mapa_y),
    .dir       (dir),
    .step_done (step_done)
  );

  always #20 CLOCK_25 = ~CLOCK_25;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // Reference model: committed position/room, pending candidate, held-cycle count.
  int m_x, m_y, m_mx, m_my, cand_x, cand_y, quiet;
  bit prev_req, exp_commit, exp_end;
  // Checker behaviour.
  int req_age, ack_at, fix_delay;
  bit blk, fix_blk, fix_never, rand_ck, spurious_en;

  function automatic int prio(input logic u, input logic d, input logic l, input logic r);
    if (!l) return 2;
    if (!d) return 1;
    if (!u) return 0;
    return 3;
  endfunction

  function automatic bit at_edge(input int d);
    case (d)
      0:       return m_y == Y_MIN;
      1:       return m_y == Y_MAX;
      2:       return m_x == X_MIN;
      default: return m_x == X_MAX;
    endcase
  endfunction

  task automatic model_reset();
    m_x = X_START; m_y = Y_START; m_mx = MAP_START; m_my = MAP_START;
    quiet = 0; prev_req = 0; exp_commit = 0; exp_end = 0; req_age = 0;
    chk_bus.chk_ack = 1'b0; chk_bus.chk_blocked = 1'b0;
  endtask

  task automatic observe();
    bit held;
    int d;
    held = !(btn_up && btn_down && btn_left && btn_right);
    d    = prio(btn_up, btn_down, btn_left, btn_right);
    if (prev_req) begin
      if (exp_commit) begin
        check_eq("commit_req_drop", chk_bus.chk_req, 0);
        check_eq("commit_pulse", step_done, 1);
        m_x = cand_x; m_y = cand_y; quiet = 0;
      end else if (exp_end) begin
        check_eq("reject_req_drop", chk_bus.chk_req, 0);
        check_eq("reject_no_pulse", step_done, 0);
        quiet = held ? 1 : 0;
      end else begin
        check_eq("req_held", chk_bus.chk_req, 1);
        check_eq("cand_x_stable", chk_bus.chk_x, cand_x);
        check_eq("cand_y_stable", chk_bus.chk_y, cand_y);
      end
    end else if (chk_bus.chk_req) begin
      check_eq("tick_spacing", quiet, TICK_MAX);
      check_eq("held_at_tick", held, 1);
      check_eq("dir_at_req", dir, d);
      check_eq("req_not_at_edge", at_edge(d), 0);
      check_eq("req_no_pulse", step_done, 0);
      cand_x = m_x + ((d == 3) ? 1 : 0) - ((d == 2) ? 1 : 0);
      cand_y = m_y + ((d == 1) ? 1 : 0) - ((d == 0) ? 1 : 0);
      check_eq("cand_x", chk_bus.chk_x, cand_x);
      check_eq("cand_y", chk_bus.chk_y, cand_y);
      quiet = 0;
    end else if (step_done) begin
      check_eq("wrap_spacing", quiet, TICK_MAX);
      check_eq("dir_at_wrap", dir, d);
      check_eq("wrap_at_edge", at_edge(d), 1);
      if (at_edge(d)) begin
        case (d)
          0:       begin m_y = Y_MAX; m_my = (m_my + 7) % 8; end
          1:       begin m_y = Y_MIN; m_my = (m_my + 1) % 8; end
          2:       begin m_x = X_MAX; m_mx = (m_mx + 7) % 8; end
          default: begin m_x = X_MIN; m_mx = (m_mx + 1) % 8; end
        endcase
      end
      quiet = 0;
    end else begin
      quiet = held ? quiet + 1 : 0;
      check_eq("missed_tick", int'(quiet <= TICK_MAX), 1);
    end
    check_eq("x_pos", x_pos, m_x);
    check_eq("y_pos", y_pos, m_y);
    check_eq("mapa_x", mapa_x, m_mx);
    check_eq("mapa_y", mapa_y, m_my);
    prev_req = chk_bus.chk_req;
  endtask

  task automatic drive_checker();
    exp_commit = 0;
    exp_end    = 0;
    if (chk_bus.chk_req) begin
      req_age++;
      if (req_age == 1) begin
        if (rand_ck) begin
          ack_at = $urandom_range(1, 5);
          blk    = $urandom_range(0, 1) == 1;
        end else begin
          ack_at = fix_never ? 99 : fix_delay + 1;
          blk    = fix_blk;
        end
      end
      if (req_age == ack_at) begin
        chk_bus.chk_ack     = 1'b1;
        chk_bus.chk_blocked = blk;
        if (blk) exp_end = 1; else exp_commit = 1;
      end else begin
        chk_bus.chk_ack     = 1'b0;
        chk_bus.chk_blocked = 1'($urandom_range(0, 1));
        if (req_age == CHK_TIMEOUT) exp_end = 1;
      end
    end else begin
      req_age             = 0;
      chk_bus.chk_ack     = spurious_en && ($urandom_range(0, 3) == 0);
      chk_bus.chk_blocked = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic cycle();
    @(negedge CLOCK_25);
    observe();
    drive_checker();
  endtask

  // kind 0: chk_req high, 1: step_done high, 2: chk_req low
  task automatic run_until(input int kind, input string tag, output int n);
    bit hit;
    hit = 0;
    n   = 0;
    while (!hit && n < 40) begin
      cycle();
      n++;
      case (kind)
        0:       hit = chk_bus.chk_req;
        1:       hit = step_done;
        default: hit = !chk_bus.chk_req;
      endcase
    end
    check_eq(tag, hit, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req"}, chk_bus.chk_req, 0);
    check_eq({tag, "_chk_x"}, chk_bus.chk_x, 0);
    check_eq({tag, "_chk_y"}, chk_bus.chk_y, 0);
    check_eq({tag, "_x"}, x_pos, X_START);
    check_eq({tag, "_y"}, y_pos, Y_START);
    check_eq({tag, "_mapa_x"}, mapa_x, MAP_START);
    check_eq({tag, "_mapa_y"}, mapa_y, MAP_START);
    check_eq({tag, "_dir"}, dir, 0);
    check_eq({tag, "_step_done"}, step_done, 0);
  endtask

  task automatic release_and_drain();
    btn_up = 1'b1; btn_down = 1'b1; btn_left = 1'b1; btn_right = 1'b1;
    repeat (12) cycle();
  endtask

  initial begin
    #20000000;
    $display("FAIL watchdog: simulation did not finish, got 0 expected 1");
    $fatal(1);
  end

  initial begin
    int n, x0, reqs, p;
    bit hit;
    rand_ck = 0; spurious_en = 0; fix_delay = 2; fix_blk = 0; fix_never = 0;
    model_reset();
    repeat (3) @(negedge CLOCK_25);
    check_reset_outputs("por");
    reset = 1'b1;

    // First step right: tick after TICK_MAX held cycles, commit right after ack.
    btn_right = 1'b0;
    run_until(0, "first_req_seen", n);
    check_eq("first_req_latency", n, TICK_MAX + 1);
    check_eq("first_chk_x", chk_bus.chk_x, 440);
    run_until(1, "first_commit_seen", n);
    check_eq("first_commit_latency", n, 3);
    check_eq("first_x_pos", x_pos, 440);
    release_and_drain();

    // Left and up together: left wins.
    btn_left = 1'b0; btn_up = 1'b0;
    run_until(0, "lu_req_seen", n);
    check_eq("lu_dir", dir, 2);
    check_eq("lu_chk_x", chk_bus.chk_x, 439);
    run_until(1, "lu_commit_seen", n);
    check_eq("lu_y_unchanged", y_pos, Y_START);
    release_and_drain();

    // Walk right off the screen.
    fix_delay = 0;
    btn_right = 1'b0;
    hit = 0;
    for (int i = 0; i < 4000 && !hit; i++) begin
      cycle();
      hit = step_done && (x_pos == X_MIN);
    end
    check_eq("right_wrap_seen", hit, 1);
    check_eq("right_wrap_mapa_x", mapa_x, 2);
    release_and_drain();

    // Walk up through two room changes: mapa_y 1 -> 0 -> 7.
    btn_up = 1'b0;
    hit = 0;
    for (int i = 0; i < 6000 && !hit; i++) begin
      cycle();
      hit = step_done && (y_pos == Y_MAX) && (mapa_y == 7);
    end
    check_eq("up_wrap_seen", hit, 1);
    check_eq("up_wrap_y", y_pos, Y_MAX);
    release_and_drain();

    // Blocked candidate: nothing moves, retry after a full tick period.
    fix_delay = 1; fix_blk = 1;
    x0 = x_pos;
    btn_right = 1'b0;
    run_until(0, "blk_req_seen", n);
    run_until(2, "blk_req_drop", n);
    check_eq("blk_x_unchanged", x_pos, x0);
    run_until(0, "blk_retry_seen", n);
    check_eq("blk_retry_gap", n, TICK_MAX);
    release_and_drain();

    // Silent checker: request gives up after CHK_TIMEOUT cycles.
    fix_never = 1;
    btn_right = 1'b0;
    run_until(0, "to_req_seen", n);
    run_until(2, "to_req_drop", n);
    check_eq("to_req_len", n, CHK_TIMEOUT);
    check_eq("to_x_unchanged", x_pos, x0);
    release_and_drain();

    // Release during the check: step still commits, then controller stays idle.
    fix_never = 0; fix_blk = 0; fix_delay = 2;
    btn_right = 1'b0;
    run_until(0, "rel_req_seen", n);
    btn_right = 1'b1;
    run_until(1, "rel_commit_seen", n);
    check_eq("rel_x_pos", x_pos, x0 + 1);
    reqs = 0;
    repeat (10) begin cycle(); reqs += chk_bus.chk_req; end
    check_eq("rel_idle_no_req", reqs, 0);

    // Asynchronous reset while a request is outstanding.
    fix_never = 1;
    btn_right = 1'b0;
    run_until(0, "rst_req_seen", n);
    reset = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    btn_right = 1'b1;
    repeat (2) @(negedge CLOCK_25);
    model_reset();
    reset = 1'b1;
    fix_never = 0;

    // Random buttons, random checker latency/verdict, stray acks outside the check.
    rand_ck = 1; spurious_en = 1;
    for (int seg = 0; seg < 60; seg++) begin
      p = $urandom_range(0, 15);
      btn_up = p[0]; btn_down = p[1]; btn_left = p[2]; btn_right = p[3];
      repeat ($urandom_range(1, 40)) cycle();
    end
    spurious_en = 0;
    release_and_drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
